// File: rtl/radix4_mult_pkg.sv
// Shared arithmetic package for the radix-4 multiply / SRT divide subsystem.
// Holds the sequencer state encoding, the radix-4 digit type and the default
// operand width used by both the multiplier and the divider.
package radix4_mult_pkg;

  // Sequencer states shared by the multiply unit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Radix-4 digit, values 0..3 (same encoding as the divider's quotient digit).
  typedef logic [1:0] digit_t;

  // Default operand width; must be even.
  localparam int DEFAULT_W = 8;

endpackage

// File: rtl/radix4_pp_sel.sv
// Radix-4 partial-product selector: picks 0, B, 2B or 3B according to the
// current multiplier digit. 3B is supplied precomputed so this block is a
// pure multiplexer. Result is W+2 bits wide so 3B never truncates.
module radix4_pp_sel
  import radix4_mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [1:0]   digit,
  input  logic [W-1:0] b,
  input  logic [W+1:0] b3,
  output logic [W+1:0] m
);

  digit_t digit_w;
  assign digit_w = digit;

  // Select the multiple of B matching the digit.
  always_comb begin
    m = '0;
    unique case (digit_w)
      2'd0: m = '0;
      2'd1: m = {2'b00, b};
      2'd2: m = {1'b0, b, 1'b0};
      2'd3: m = b3;
      default: m = '0;
    endcase
  end

endmodule

// File: rtl/radix4_mult.sv
// Sequential radix-4 multiply(-accumulate): P = A*B (+ C), two multiplier
// bits retired per cycle, W/2 iterations per result.
// Optional feature macro: RADIX4_MULT_ACC_EN adds addend port C and seeds the
// accumulator with it; without it the accumulator starts from zero.
// W must be even.
module radix4_mult
  import radix4_mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
`ifdef RADIX4_MULT_ACC_EN
  input  logic [W-1:0]   C,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] P
);

  localparam int ITER = W / 2;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_t state_reg, state_next;

  logic [W-1:0]     a_sh_reg;
  logic [W-1:0]     b_reg;
  logic [W+1:0]     b3_reg;
  logic [2*W-1:0]   acc_reg;
  logic [2*W-1:0]   p_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             accept;
  logic             last_iter;
  digit_t           digit;
  logic [W+1:0]     pp;
  logic [2*W-1:0]   pp_ext;
  logic [2*W-1:0]   acc_next;
  logic [W+1:0]     b3_in;
  logic [2*W-1:0]   acc_init;

  // A new operation is taken only when the unit is not computing.
  assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_iter = (cnt_reg == LAST_CNT);
  assign digit     = a_sh_reg[1:0];

  // 3B = B + 2B, widened so it cannot overflow.
  assign b3_in = {2'b00, B} + {1'b0, B, 1'b0};

`ifdef RADIX4_MULT_ACC_EN
  assign acc_init = (2*W)'(C);
`else
  assign acc_init = '0;
`endif

  radix4_pp_sel #(.W(W)) u_pp_sel (
    .digit (digit),
    .b     (b_reg),
    .b3    (b3_reg),
    .m     (pp)
  );

  // Digit i carries weight 4^i, so the multiple is shifted by 2*cnt.
  assign pp_ext   = (2*W)'(pp);
  assign acc_next = acc_reg + (pp_ext << {cnt_reg, 1'b0});

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE/DONE wait for start, CALC runs ITER cycles.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (start) state_next = CALC;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then one radix-4 step per cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_sh_reg <= '0;
      b_reg    <= '0;
      b3_reg   <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      p_reg    <= '0;
    end else if (accept) begin
      a_sh_reg <= A;
      b_reg    <= B;
      b3_reg   <= b3_in;
      acc_reg  <= acc_init;
      cnt_reg  <= '0;
    end else if (state_reg == CALC) begin
      acc_reg  <= acc_next;
      a_sh_reg <= a_sh_reg >> 2;
      cnt_reg  <= cnt_reg + 1'b1;
      if (last_iter) begin
        p_reg <= acc_next;
      end
    end
  end

  assign busy = (state_reg == CALC);
  assign done = (state_reg == DONE);
  assign P    = p_reg;

endmodule

// File: tb/tb_radix4_mult.sv
// Self-checking bench for radix4_mult (W=8). Works with or without
// RADIX4_MULT_ACC_EN. A cycle-level behavioural model tracks when each
// accepted operation completes and what P must be; a compare process checks
// busy/done/P every cycle, and directed cases pin literal results.
module tb_radix4_mult;

  localparam int W    = 8;
  localparam int ITER = W / 2;
`ifdef RADIX4_MULT_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [W-1:0]   c = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  radix4_mult #(.W(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .A      (a),
    .B      (b),
`ifdef RADIX4_MULT_ACC_EN
    .C      (c),
`endif
    .busy   (busy),
    .done   (done),
    .P      (p)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An operation accepted at edge k finishes at edge k+ITER. The unit accepts
  // when nothing has been accepted yet or the last operation finished before
  // this edge. Result = A*B + C (C forced to 0 when the addend is absent).
  int             edge_n = 0;
  int             k = 0;
  bit             act = 1'b0;
  logic [2*W-1:0] res = '0;
  logic [2*W-1:0] exp_p = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act   <= 1'b0;
      exp_p <= '0;
    end else begin
      edge_n <= edge_n + 1;
      if (act && (edge_n + 1 == k + ITER)) exp_p <= res;
      if (start && (!act || (edge_n + 1 > k + ITER))) begin
        act <= 1'b1;
        k   <= edge_n + 1;
        res <= (2*W)'(a) * (2*W)'(b) + (2*W)'(c);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  bit exp_busy, exp_done;
  always @(negedge clk) begin
    if (resetn) begin
      exp_busy = act && ((edge_n - k) < ITER);
      exp_done = act && ((edge_n - k) >= ITER);
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("P", 32'(p), 32'(exp_p));
      check("busy_done_excl", 32'(busy & done), 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  int t0 = 0;

  // Present operands with start for one edge; return at the negedge after acceptance.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] cv);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    c = ACC ? cv : '0;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    c = ACC ? W'($urandom) : '0;
    t0 = edge_n;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
  endtask

  // Wait (bounded) for done, check latency and the literal result.
  task automatic wait_done(input string name, input logic [2*W-1:0] expv);
    int guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_latency"}, 32'(edge_n - t0), 32'(ITER));
    check({name, "_P"}, 32'(p), 32'(expv));
  endtask

  task automatic run_txn(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] cv, input logic [2*W-1:0] expv);
    launch(av, bv, cv);
    wait_done(name, expv);
    $display("txn %s A=%0h B=%0h C=%0h P=%0h", name, av, bv, ACC ? cv : '0, p);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] ra, rb, rc;
    logic [2*W-1:0] rexp;

    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_P", 32'(p), 32'd0);
    @(negedge clk);
    #2 resetn = 1'b1;

    run_txn("mac_200", 8'h02, 8'h50, 8'h28, ACC ? 16'h00C8 : 16'h00A0);
    run_txn("max", 8'hFF, 8'hFF, 8'hFF, ACC ? 16'hFF00 : 16'hFE01);
    run_txn("zero", 8'h00, 8'hAB, 8'h00, 16'h0000);
    run_txn("one", 8'h01, 8'h01, 8'h00, 16'h0001);

    // Asynchronous reset two cycles into CALC.
    launch(8'h03, 8'h03, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_P", 32'(p), 32'd0);
    $display("txn midreset busy=%0d done=%0d P=%0h", busy, done, p);
    @(negedge clk);
    #2 resetn = 1'b1;
    run_txn("after_reset", 8'h03, 8'h03, 8'h00, 16'h0009);

    // start during CALC is ignored.
    launch(8'h10, 8'h10, 8'h00);
    start = 1'b1;
    a = 8'h77;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", 16'h0100);
    $display("txn ignore_start A=10 B=10 P=%0h", p);

    // Restart from DONE: done drops, old P held until the final edge.
    launch(8'hFF, 8'h01, 8'h00);
    check("hold_P", 32'(p), 32'h0100);
    wait_done("restart", 16'h00FF);
    $display("txn restart A=ff B=01 P=%0h", p);

    run_txn("seven_nine", 8'h07, 8'h09, 8'h00, 16'h003F);

    // Random sweep.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = W'($urandom);
      rexp = (2*W)'(ra) * (2*W)'(rb) + (ACC ? (2*W)'(rc) : '0);
      run_txn("rand", ra, rb, rc, rexp);
    end

    // Back-to-back: start held high with changing operands.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3 * (ITER + 1); i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = ACC ? W'($urandom) : '0;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (ITER + 2) @(negedge clk);
    check("b2b_final_done", 32'(done), 32'd1);
    $display("txn back_to_back P=%0h", p);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/radix4_mult.md
# radix4_mult

Sequential radix-4 multiply-accumulate unit computing P = A×B (+ C), two multiplier bits per cycle. It is the inverse of the SRT radix-4 divider: the divider's quotient, divisor and remainder feed A, B and C, and P rebuilds the dividend, N = Q×D + R. It is used for round-trip self-checking and as the multiply datapath in the same arithmetic subsystem. Digit set {0,1,2,3}, with a precomputed 3B multiple, matching the divider's quotient-digit encoding.

## Interface
- W, default 8: operand width; must be even; ITER = W/2 iterations.
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  W  multiplier (quotient side); captured on the accepting edge.
- B  input  W  multiplicand (divisor side); captured on the accepting edge.
- C  input  W  addend (remainder side); present only when RADIX4_MULT_ACC_EN is defined.
- busy  output  1  high while in CALC.
- done  output  1  high while in DONE.
- P  output  2W  result register.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE with start=1: on that edge, capture a_sh←A, b←B, b3←3·B (W+2 bits), acc←C zero-extended (or 0 without the macro), cnt←0. Next state is CALC.
- CALC, iteration i (cnt=i): digit = a_sh[1:0]. Multiple m ∈ {0, B, 2B, 3B}. acc ← acc + (m << 2i). a_sh ← a_sh >> 2. cnt ← cnt+1.
- On the iteration with cnt=ITER−1: P ← updated acc; next state is DONE.
- DONE: done=1 and P is held. start=1 restarts exactly as from IDLE, capturing new operands; done falls on that edge. With start=0, remain in DONE.
- start during CALC is ignored. There is no abort input.
- Width rule: acc and P are 2W bits. The maximum (2^W−1)²+(2^W−1) < 2^(2W), so the result never overflows. All arithmetic is unsigned.
- Inputs are not re-sampled during CALC; A/B/C may change freely after the accepting edge.

## Timing
- Reset (asynchronous, resetn=0): state=IDLE; busy=0, done=0, P=0, acc=0, cnt=0, a_sh=0, b=0, b3=0. Reset takes effect immediately, including mid-CALC, and discards any partial result.
- Latency: start is accepted at edge k. busy=1 from after edge k until after edge k+ITER. P is valid and done=1 after edge k+ITER (4 cycles for W=8).
- Throughput: one result per ITER+1 cycles when start is held high in DONE.
- P changes only at the final CALC edge or at reset. It holds the previous result throughout CALC.
- busy and done are never both high.

## Configuration
- RADIX4_MULT_ACC_EN defined: port C exists; acc initialises to C; P = A×B + C. This mode is used for divider round-trip checks.
- Not defined: port C is absent; acc initialises to 0; P = A×B. Timing is identical in both modes.

## Structure
- Shared arithmetic package:
  - state encoding constants IDLE=2'b00, CALC=2'b01, DONE=2'b10;
  - the radix-4 digit type (2 bits);
  - default operand width 8.
  - The divider uses the same digit type.
- Sub-module radix4_pp_sel: combinational selection of the multiple from digit, b and b3 (0/B/2B/3B, W+2 bits). It mirrors the divider's product block.
- The top level contains the FSM, counter, shift register, accumulator and P register.

## Test plan
- Macro on, W=8; A=2, B=0x50, C=0x28 → P=0x00C8 (200). done rises exactly 4 cycles after the start edge; busy is high for 4 cycles.
- Macro on; A=0xFF, B=0xFF, C=0xFF → P=0xFF00 with no overflow.
- A=0x00, B=0xAB, C=0 → P=0x0000. Also A=0x01, B=0x01 → P=0x0001.
- Start A=3, B=3 and assert resetn=0 after 2 CALC cycles → immediately busy=0, done=0, P=0, state IDLE. After release, start A=3, B=3 → P=9.
- Start A=0x10, B=0x10. Pulse start with A=0x77 during CALC → ignored; P=0x0100. In DONE, start with A=0xFF, B=0x01 → done drops next cycle, then P=0x00FF; the old P is held during CALC.
- Macro off; A=7, B=9 → P=0x003F. Random sweep against the A×B reference model, checking latency on every transaction.
